// File: rtl/posit_chk_pkg.sv
// Shared types and helpers for the streaming posit checker.
package posit_chk_pkg;

  typedef enum logic [1:0] {NORMAL, ZERO, NAR} pclass_t;

  typedef struct packed {
    pclass_t cls;
    logic    sign;
  } opnd_info_t;

  function automatic int scale_w(input int n, input int es);
    return $clog2(n) + es + 2;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/posit_field_decode.sv
// Combinational posit field decoder: special class, sign, scale, left-justified
// fraction and the number of fraction bits physically present in the word.
module posit_field_decode
  import posit_chk_pkg::*;
#(
  parameter  int N      = 32,
  parameter  int ES     = 2,
  parameter  int FRAC_W = 12,
  localparam int SW     = scale_w(N, ES),
  localparam int FC_W   = $clog2(N) + 1
) (
  input  logic [N-1:0]         p,
  output pclass_t              cls,
  output logic                 sign,
  output logic signed [SW-1:0] scale,
  output logic [FRAC_W-1:0]    frac,
  output logic [FC_W-1:0]      frac_count
);

  logic [N-1:0]          mag;
  logic [N-2:0]          body;
  logic [N-2:0]          after;
  logic [N-2+FRAC_W:0]   fwide;
  logic                  run_bit;
  logic                  running;
  int                    k;
  int                    exp_val;
  int                    scale_i;
  int                    fc_i;

  always_comb begin
    mag     = p[N-1] ? (~p + N'(1)) : p;
    body    = (N-1)'(mag);
    run_bit = body[N-2];
    k       = 0;
    running = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (running && (body[i] == run_bit)) k = k + 1;
      else running = 1'b0;
    end
    // Drop regime run and terminator; exponent then fraction sit at the top.
    after   = body << (k + 1);
    exp_val = int'(after >> (N - 1 - ES));
    scale_i = (run_bit ? (k - 1) : -k) * (1 << ES) + exp_val;
    scale   = SW'(scale_i);
    fwide   = {after << ES, {FRAC_W{1'b0}}};
    frac    = FRAC_W'(fwide >> (N - 1));
    fc_i    = N - 2 - k - ES;
    if (fc_i < 0) fc_i = 0;
    frac_count = FC_W'(fc_i);
    sign       = p[N-1];
    if (p == '0)                          cls = ZERO;
    else if (p == {1'b1, {(N-1){1'b0}}})  cls = NAR;
    else                                  cls = NORMAL;
  end

endmodule

// File: rtl/posit_check_stream.sv
// Three-stage streaming comparison of a full-width posit against a reduced-width
// checker posit, with a global-stall handshake and saturating event counters.
module posit_check_stream
  import posit_chk_pkg::*;
#(
  parameter  int FULL_N   = 32,
  parameter  int CHK_N    = 16,
  parameter  int ES       = 2,
  parameter  int FRAC_W   = 12,
  parameter  int TOL      = 1,
  parameter  int MIN_FRAC = 3,
  parameter  int CNT_W    = 16,
  localparam int SCALE_W  = scale_w(FULL_N, ES),
  localparam int KEY_W    = SCALE_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_N-1:0] full_posit,
  input  logic [CHK_N-1:0]  chk_posit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_punt,
  output logic              out_error,
  output logic [KEY_W-1:0]  out_diff,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  punt_count,
  output logic [CNT_W-1:0]  error_count,
  output logic              sticky_error
);

  localparam int CSCALE_W = scale_w(CHK_N, ES);
  localparam int FFC_W    = $clog2(FULL_N) + 1;
  localparam int CFC_W    = $clog2(CHK_N) + 1;

  typedef struct packed {
    opnd_info_t          full;
    opnd_info_t          chk;
    logic [SCALE_W-1:0]  full_scale;
    logic [CSCALE_W-1:0] chk_scale;
    logic [FRAC_W-1:0]   full_frac;
    logic [FRAC_W-1:0]   chk_frac;
    logic [FFC_W-1:0]    full_fc;
  } s1_t;

  typedef struct packed {
    opnd_info_t       full;
    opnd_info_t       chk;
    logic [KEY_W-1:0] key_full;
    logic [KEY_W-1:0] key_chk;
    logic             punt;
  } s2_t;

  pclass_t             full_cls, chk_cls;
  logic                full_sign, chk_sign;
  logic [SCALE_W-1:0]  full_scale;
  logic [CSCALE_W-1:0] chk_scale;
  logic [FRAC_W-1:0]   full_frac, chk_frac;
  logic [FFC_W-1:0]    full_fc;
  logic [CFC_W-1:0]    unused_chk_fc;

  logic advance, deliver;
  logic s1_valid, s2_valid;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic signed [KEY_W:0] key_delta;
  logic [KEY_W:0]        key_abs;
  logic [KEY_W-1:0]      diff_sat, diff_d;
  logic                  error_d;

  posit_field_decode #(.N(FULL_N), .ES(ES), .FRAC_W(FRAC_W)) u_dec_full (
    .p(full_posit), .cls(full_cls), .sign(full_sign), .scale(full_scale),
    .frac(full_frac), .frac_count(full_fc)
  );

  posit_field_decode #(.N(CHK_N), .ES(ES), .FRAC_W(FRAC_W)) u_dec_chk (
    .p(chk_posit), .cls(chk_cls), .sign(chk_sign), .scale(chk_scale),
    .frac(chk_frac), .frac_count(unused_chk_fc)
  );

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign deliver  = out_valid && out_ready;

  always_comb begin
    s1_d.full       = '{cls: full_cls, sign: full_sign};
    s1_d.chk        = '{cls: chk_cls, sign: chk_sign};
    s1_d.full_scale = full_scale;
    s1_d.chk_scale  = chk_scale;
    s1_d.full_frac  = full_frac;
    s1_d.chk_frac   = chk_frac;
    s1_d.full_fc    = full_fc;
  end

  always_comb begin
    s2_d.full     = s1_q.full;
    s2_d.chk      = s1_q.chk;
    s2_d.key_full = {s1_q.full_scale, s1_q.full_frac};
    s2_d.key_chk  = {SCALE_W'($signed(s1_q.chk_scale)), s1_q.chk_frac};
    s2_d.punt     = (s1_q.full.cls == NORMAL) && (int'(s1_q.full_fc) < MIN_FRAC);
  end

  always_comb begin
    key_delta = $signed({s2_q.key_full[KEY_W-1], s2_q.key_full})
              - $signed({s2_q.key_chk[KEY_W-1], s2_q.key_chk});
    key_abs   = key_delta[KEY_W] ? $unsigned(-key_delta) : $unsigned(key_delta);
    diff_sat  = key_abs[KEY_W] ? '1 : key_abs[KEY_W-1:0];
    diff_d    = diff_sat;
    error_d   = diff_sat > KEY_W'(TOL);
    if (s2_q.full.cls != NORMAL || s2_q.chk.cls != NORMAL) begin
      error_d = (s2_q.full.cls != s2_q.chk.cls);
      diff_d  = '0;
    end else if (s2_q.full.sign != s2_q.chk.sign) begin
      error_d = 1'b1;
      diff_d  = '0;
    end
    // An unreliable full posit cannot be used to accuse the checker.
    if (s2_q.punt) error_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_punt  <= 1'b0;
      out_error <= 1'b0;
      out_diff  <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_q      <= s1_d;
      s2_valid  <= s1_valid;
      s2_q      <= s2_d;
      out_valid <= s2_valid;
      out_punt  <= s2_q.punt;
      out_error <= error_d;
      out_diff  <= diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      sample_count <= '0;
      punt_count   <= '0;
      error_count  <= '0;
      sticky_error <= 1'b0;
    end else if (deliver) begin
      sample_count <= CNT_W'(sat_inc(64'(sample_count), CNT_W));
      if (out_punt) punt_count <= CNT_W'(sat_inc(64'(punt_count), CNT_W));
      if (out_error) begin
        error_count  <= CNT_W'(sat_inc(64'(error_count), CNT_W));
        sticky_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_posit_check_stream.sv
// Scoreboard bench for posit_check_stream: directed vectors, backpressure,
// counter saturation, clear priority and reset flush.
module tb_posit_check_stream;
  import posit_chk_pkg::*;

  localparam int FULL_N = 32;
  localparam int CHK_N  = 16;
  localparam int ES     = 2;
  localparam int FRAC_W = 12;
  localparam int KEY_W  = scale_w(FULL_N, ES) + FRAC_W;

  typedef struct {
    logic             punt;
    logic             error;
    logic [KEY_W-1:0] diff;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clr_counts;
  logic [FULL_N-1:0] full_posit;
  logic [CHK_N-1:0]  chk_posit;

  logic             in_ready, out_valid, out_punt, out_error, sticky_error;
  logic [KEY_W-1:0] out_diff;
  logic [15:0]      sample_count, punt_count, error_count;

  logic             in_ready4, out_valid4, out_punt4, out_error4, sticky_error4;
  logic [KEY_W-1:0] out_diff4;
  logic [3:0]       sample_count4, punt_count4, error_count4;

  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   m_samples = 0, m_punts = 0, m_errs = 0;
  logic m_sticky = 1'b0;
  exp_t q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  posit_check_stream #(.FULL_N(FULL_N), .CHK_N(CHK_N), .ES(ES), .FRAC_W(FRAC_W),
                       .TOL(1), .MIN_FRAC(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .full_posit(full_posit), .chk_posit(chk_posit), .out_valid(out_valid),
    .out_ready(out_ready), .out_punt(out_punt), .out_error(out_error),
    .out_diff(out_diff), .clr_counts(clr_counts), .sample_count(sample_count),
    .punt_count(punt_count), .error_count(error_count), .sticky_error(sticky_error)
  );

  posit_check_stream #(.FULL_N(FULL_N), .CHK_N(CHK_N), .ES(ES), .FRAC_W(FRAC_W),
                       .TOL(1), .MIN_FRAC(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .full_posit(full_posit), .chk_posit(chk_posit), .out_valid(out_valid4),
    .out_ready(out_ready), .out_punt(out_punt4), .out_error(out_error4),
    .out_diff(out_diff4), .clr_counts(clr_counts), .sample_count(sample_count4),
    .punt_count(punt_count4), .error_count(error_count4), .sticky_error(sticky_error4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_samples"}, 64'(sample_count), 64'(m_samples));
    check({tag, "_punts"},   64'(punt_count),   64'(m_punts));
    check({tag, "_errors"},  64'(error_count),  64'(m_errs));
    check({tag, "_sticky"},  64'(sticky_error), 64'(m_sticky));
  endtask

  // Called at posedge+1; returns at accept edge+1 with in_valid dropped.
  task automatic send(input logic [FULL_N-1:0] f, input logic [CHK_N-1:0] c,
                      input logic p, input logic e, input logic [KEY_W-1:0] d);
    bit ok = 1'b0;
    in_valid   = 1'b1;
    full_posit = f;
    chk_posit  = c;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for full %0h", f);
    end else begin
      q.push_back('{punt: p, error: e, diff: d});
      accepted++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && q.size() > 0; n++) begin
      @(posedge clk);
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, expected 0", tag, q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: punt %0b error %0b diff %0h, expected none",
                 out_punt, out_error, out_diff);
      end else begin
        e_mon = q.pop_front();
        check("out_punt",  64'(out_punt),  64'(e_mon.punt));
        check("out_error", 64'(out_error), 64'(e_mon.error));
        check("out_diff",  64'(out_diff),  64'(e_mon.diff));
        if (clr_counts) begin
          m_samples = 0; m_punts = 0; m_errs = 0; m_sticky = 1'b0;
        end else begin
          m_samples++;
          if (e_mon.punt) m_punts++;
          if (e_mon.error) begin
            m_errs++;
            m_sticky = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    bit   ok;
    int   acc0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_counts = 1'b0;
    full_posit = '0; chk_posit = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready",  64'(in_ready), 1);
    check("rst_out_punt",  64'(out_punt), 0);
    check("rst_out_error", 64'(out_error), 0);
    check("rst_out_diff",  64'(out_diff), 0);
    check_counts("rst");

    // Latency: accepted at edge t, visible after edge t+2.
    send(32'h4000_0000, 16'h4000, 1'b0, 1'b0, 0);
    check("lat_early_0", 64'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_early_1", 64'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_on", 64'(out_valid), 1);
    drain("lat");

    send(32'h4000_8000, 16'h4000, 1'b0, 1'b0, 1);
    send(32'h4001_0000, 16'h4000, 1'b0, 1'b1, 2);
    send(32'h4010_0000, 16'h4000, 1'b0, 1'b1, 32);
    send(32'hC000_0000, 16'hC000, 1'b0, 1'b0, 0);
    send(32'hC000_8000, 16'hC000, 1'b0, 1'b0, 1);
    send(32'h4000_0000, 16'hC000, 1'b0, 1'b1, 0);
    send(32'h7FFF_FFE0, 16'h0000, 1'b1, 1'b0, 0);
    send(32'h7FFF_FF00, 16'h0000, 1'b0, 1'b1, 0);
    send(32'h8000_0000, 16'h8000, 1'b0, 1'b0, 0);
    send(32'h8000_0000, 16'h0000, 1'b0, 1'b1, 0);
    send(32'h0000_0000, 16'h0000, 1'b0, 1'b0, 0);
    drain("directed");
    check_counts("directed");

    // Backpressure: pipeline fills with three, then stalls.
    acc0 = accepted;
    fork
      begin
        send(32'h4000_0000, 16'h4000, 1'b0, 1'b0, 0);
        send(32'h4000_8000, 16'h4000, 1'b0, 1'b0, 1);
        send(32'h4001_0000, 16'h4000, 1'b0, 1'b1, 2);
        send(32'h4010_0000, 16'h4000, 1'b0, 1'b1, 32);
        send(32'h4000_0000, 16'hC000, 1'b0, 1'b1, 0);
      end
      begin
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", 64'(accepted - acc0), 3);
        check("bp_in_ready", 64'(in_ready), 0);
        check("bp_out_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check_counts("bp");

    // Saturation of the 4-bit counters.
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    m_samples = 0; m_punts = 0; m_errs = 0; m_sticky = 1'b0;
    for (int i = 0; i < 20; i++) send(32'h4000_0000, 16'hC000, 1'b0, 1'b1, 0);
    drain("sat");
    check_counts("sat");
    check("sat_errors4",  64'(error_count4), 15);
    check("sat_samples4", 64'(sample_count4), 15);
    check("sat_sticky4",  64'(sticky_error4), 1);

    // Clear coincident with a delivery wins.
    out_ready = 1'b0;
    send(32'h4000_0000, 16'hC000, 1'b0, 1'b1, 0);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clr_wait: out_valid never rose, expected 1");
    end
    clr_counts = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check_counts("clr");
    check("clr_errors",   64'(error_count), 0);
    check("clr_errors4",  64'(error_count4), 0);
    check("clr_sticky4",  64'(sticky_error4), 0);

    // Reset mid-flight drops the sample without counting it.
    send(32'h4000_0000, 16'hC000, 1'b0, 1'b1, 0);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("flush_out_valid", 64'(out_valid), 0);
    check_counts("flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
